// File: rtl/fifo_pkg.sv
// Shared FIFO constants and pointer-width helper, also used by the UART top.
package fifo_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_AE_THRESH = 2;
    localparam int DEF_AF_MARGIN = 2;

    // Address bits needed for a power-of-two DEPTH; pointers carry one extra wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH simple dual-port storage: one synchronous write port, one asynchronous read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with thresholds and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is registered read.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - DEF_AF_MARGIN,
    parameter int AE_THRESH = DEF_AE_THRESH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      data_in,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      data_out,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    localparam int PTR_W = ptr_w(DEPTH);

    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [WIDTH-1:0] head;
    logic             rd_acc;
    logic             wr_acc;

    // Extra pointer MSB distinguishes full from empty; the subtraction wraps naturally.
    assign level        = wr_ptr - rd_ptr;
    assign empty        = (level == '0);
    assign full         = (level == (PTR_W + 1)'(DEPTH));
    assign almost_full  = (level >= (PTR_W + 1)'(AF_THRESH));
    assign almost_empty = (level <= (PTR_W + 1)'(AE_THRESH));

    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr[PTR_W-1:0]),
        .wdata (data_in),
        .raddr (rd_ptr[PTR_W-1:0]),
        .rdata (head)
    );

    // A rejection in the same cycle as err_clr keeps its flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            overflow  <= (wr_en & ~wr_acc) | (overflow & ~err_clr);
            underflow <= (rd_en & ~rd_acc) | (underflow & ~err_clr);
        end
    end

`ifdef FIFO_FWFT_EN
    assign data_out   = head;
    assign data_valid = ~empty;
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= rd_acc;
            if (rd_acc) data_out <= head;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param (WIDTH=8, DEPTH=16); honours FIFO_FWFT_EN when defined.
module tb_fifo_sync_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] data_in;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] data_out;
    logic       data_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] level;
    logic       overflow;
    logic       underflow;

    int tests = 0;
    int fails = 0;
    logic [7:0] q[$];
    logic [7:0] d;
    logic [7:0] e;

    fifo_sync_param #(.WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .level        (level),
        .overflow     (overflow),
        .underflow    (underflow),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one clock cycle, then sample 1 time unit after the rising edge.
    task automatic cyc(input logic w, input logic [7:0] din, input logic r, input logic c);
        wr_en = w; data_in = din; rd_en = r; err_clr = c;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    endtask

    // Pop (optionally with a simultaneous write) and check the word delivered.
    task automatic xfer_chk(input logic w, input logic [7:0] din, input logic [7:0] exp, input string tag);
`ifdef FIFO_FWFT_EN
        chk({tag, "_data"}, 32'(data_out), 32'(exp));
        chk({tag, "_vld"}, 32'(data_valid), 32'd1);
        cyc(w, din, 1'b1, 1'b0);
`else
        cyc(w, din, 1'b1, 1'b0);
        chk({tag, "_data"}, 32'(data_out), 32'(exp));
        chk({tag, "_vld"}, 32'(data_valid), 32'd1);
`endif
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_level"}, 32'(level), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_ae"}, 32'(almost_empty), 32'd1);
        chk({tag, "_af"}, 32'(almost_full), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
        chk({tag, "_udf"}, 32'(underflow), 32'd0);
        chk({tag, "_vld"}, 32'(data_valid), 32'd0);
`ifndef FIFO_FWFT_EN
        chk({tag, "_dout"}, 32'(data_out), 32'd0);
`endif
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; data_in = '0;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        chk_reset_state("rst");

        // T1: fill with 0x00..0x0F, then one rejected write
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0);
            chk("t1_level", 32'(level), 32'(i + 1));
            chk("t1_af", 32'(almost_full), 32'((i + 1) >= 14));
            chk("t1_ae", 32'(almost_empty), 32'((i + 1) <= 2));
        end
        chk("t1_full", 32'(full), 32'd1);
        cyc(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("t1_ovf", 32'(overflow), 32'd1);
        chk("t1_level_ovf", 32'(level), 32'd16);

        // T2: drain in order, then one rejected read
        for (int i = 0; i < 16; i++) begin
            xfer_chk(1'b0, 8'h00, 8'(i), "t2_rd");
            chk("t2_level", 32'(level), 32'(15 - i));
        end
        chk("t2_empty", 32'(empty), 32'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t2_udf", 32'(underflow), 32'd1);
        chk("t2_vld_after", 32'(data_valid), 32'd0);
`ifndef FIFO_FWFT_EN
        chk("t2_dout_hold", 32'(data_out), 32'h0F);
`endif
        // err_clr with a simultaneous rejected read: underflow stays, overflow clears
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        chk("clr_setwins_udf", 32'(underflow), 32'd1);
        chk("clr_setwins_ovf", 32'(overflow), 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_udf", 32'(underflow), 32'd0);

        // T3: simultaneous read/write while full
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        chk("t3_full", 32'(full), 32'd1);
        xfer_chk(1'b1, 8'hAA, 8'h10, "t3_rw");
        chk("t3_level", 32'(level), 32'd16);
        chk("t3_ovf", 32'(overflow), 32'd0);
        for (int i = 1; i < 16; i++) xfer_chk(1'b0, 8'h00, 8'(8'h10 + i), "t3_rd");
        xfer_chk(1'b0, 8'h00, 8'hAA, "t3_last");
        chk("t3_empty", 32'(empty), 32'd1);

        // T4: read+write on empty FIFO
        cyc(1'b1, 8'h55, 1'b1, 1'b0);
        chk("t4_level", 32'(level), 32'd1);
        chk("t4_udf", 32'(underflow), 32'd1);
`ifdef FIFO_FWFT_EN
        chk("t4_vld", 32'(data_valid), 32'd1);
        chk("t4_dout", 32'(data_out), 32'h55);
`else
        chk("t4_vld", 32'(data_valid), 32'd0);
`endif
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t4_clr_udf", 32'(underflow), 32'd0);
        chk("t4_clr_ovf", 32'(overflow), 32'd0);
        xfer_chk(1'b0, 8'h00, 8'h55, "t4_rd");
        chk("t4_empty", 32'(empty), 32'd1);

        // T5: streaming through pointer wrap with a scoreboard
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom_range(0, 255));
            q.push_back(d);
            cyc(1'b1, d, 1'b0, 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom_range(0, 255));
            e = q.pop_front();
            q.push_back(d);
            xfer_chk(1'b1, d, e, "t5_rw");
            chk("t5_level", 32'(level), 32'd3);
        end
        while (q.size() > 0) begin
            e = q.pop_front();
            xfer_chk(1'b0, 8'h00, e, "t5_drain");
        end
        chk("t5_empty", 32'(empty), 32'd1);

        // T6: reset mid-burst with level 9 and flags set
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        chk("t6_level9", 32'(level), 32'd9);
        chk("t6_udf_pre", 32'(underflow), 32'd1);
        reset = 1'b1;
        cyc(1'b1, 8'h77, 1'b1, 1'b0);
        reset = 1'b0;
        chk_reset_state("t6");
        cyc(1'b1, 8'h33, 1'b0, 1'b0);
        xfer_chk(1'b0, 8'h00, 8'h33, "t6_after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
